// File: rtl/dcache_2way_top.sv
// dcache_2way_top
// ---------------------------------------------------------------------------
// Two-way set-associative, write-back, write-allocate data cache between a
// CPU word port and a line-wide memory port. Tag, valid, dirty, LRU and line
// data are held in internal register arrays.
//
// Ports
//   clk_i           clock, all state on posedge
//   rst_i           asynchronous active-low reset
//   mem_data_i      refill line returned by memory
//   mem_ack_i       memory completion, single-cycle pulse
//   mem_data_o      write-back line (victim line)
//   mem_addr_o      line address, low OFF_BITS zero
//   mem_enable_o    memory request valid (WB / REFILL states)
//   mem_write_o     1 = write-back, 0 = refill read
//   p1_data_i       CPU store data
//   p1_addr_i       CPU byte address
//   p1_MemRead_i    load request
//   p1_MemWrite_i   store request
//   p1_data_o       load data from the hit way (0 when not hitting)
//   p1_stall_o      CPU must hold its request and retry
//   hit_cnt_o       first-try hits, saturating
//   miss_cnt_o      detected misses, saturating
//   dbg_state       current FSM state, for observation
//
// Handshakes
//   CPU side: a request (MemRead or MemWrite) is accepted in the cycle where
//   p1_stall_o is low; the CPU keeps address/data/request stable while
//   p1_stall_o is high. Memory side: mem_enable_o is the request valid and
//   stays high with stable address/data until the cycle mem_ack_i is sampled
//   high; mem_ack_i in any other state is ignored.
// ---------------------------------------------------------------------------
module dcache_2way_top #(
    parameter int ADDR_W   = 32,
    parameter int WORD_W   = 32,
    parameter int LINE_W   = 256,
    parameter int SET_BITS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [2:0]        dbg_state
);

    localparam int OFF_BITS = $clog2(LINE_W / 8);
    localparam int TAG_W    = ADDR_W - SET_BITS - OFF_BITS;
    localparam int SETS     = 1 << SET_BITS;
    localparam int WORDS    = LINE_W / WORD_W;
    localparam int WORD_OFF = $clog2(WORD_W / 8);
    localparam int WIDX_W   = OFF_BITS - WORD_OFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MISS   = 3'd1,
        S_WB     = 3'd2,
        S_REFILL = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state_q;
    logic   prev_done_q;

    // Storage arrays; data and tags are not reset (valid bits guard them)
    logic [LINE_W-1:0] data_q  [2][SETS];
    logic [TAG_W-1:0]  tag_q   [2][SETS];
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   dirty_q [2];
    logic [SETS-1:0]   lru_q;

    // Miss context captured when leaving IDLE
    logic [TAG_W-1:0]    miss_tag_q;
    logic [SET_BITS-1:0] miss_set_q;
    logic                victim_q;

    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Address decode
    logic [TAG_W-1:0]    req_tag;
    logic [SET_BITS-1:0] req_set;
    logic [WIDX_W-1:0]   req_word;
    logic                req;

    assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_set  = p1_addr_i[OFF_BITS +: SET_BITS];
    assign req_word = p1_addr_i[OFF_BITS-1 : WORD_OFF];
    assign req      = p1_MemRead_i | p1_MemWrite_i;

    // Lookup
    logic match0;
    logic match1;
    logic hit;
    logic hit_way;
    logic victim;
    logic store_hit;
    logic refill_done;

    assign match0  = valid_q[0][req_set] & (tag_q[0][req_set] == req_tag);
    assign match1  = valid_q[1][req_set] & (tag_q[1][req_set] == req_tag);
    assign hit     = req & (state_q == S_IDLE) & (match0 | match1);
    // Way 0 wins if both ever matched; a line can only be filled into one way
    assign hit_way = ~match0;

    // First invalid way, otherwise the least recently used one
    always_comb begin
        victim = lru_q[req_set];
        if (!valid_q[0][req_set]) begin
            victim = 1'b0;
        end else if (!valid_q[1][req_set]) begin
            victim = 1'b1;
        end
    end

    assign store_hit   = hit & p1_MemWrite_i;
    assign refill_done = (state_q == S_REFILL) & mem_ack_i;

    // Word read from, and store merge into, the hit line
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] store_line;
    logic [WORD_W-1:0] rd_word;

    always_comb begin
        hit_line   = data_q[hit_way][req_set];
        store_line = hit_line;
        rd_word    = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (req_word == w[WIDX_W-1:0]) begin
                rd_word                         = hit_line[w*WORD_W +: WORD_W];
                store_line[w*WORD_W +: WORD_W]  = p1_data_i;
            end
        end
    end

    assign p1_data_o  = hit ? rd_word : '0;
    assign p1_stall_o = req & ~hit;

    // Control state, metadata and counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            prev_done_q <= 1'b0;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            dirty_q[0]  <= '0;
            dirty_q[1]  <= '0;
            lru_q       <= '0;
            miss_tag_q  <= '0;
            miss_set_q  <= '0;
            victim_q    <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            prev_done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (req && !hit) begin
                        miss_tag_q <= req_tag;
                        miss_set_q <= req_set;
                        victim_q   <= victim;
                        state_q    <= S_MISS;
                        if (miss_cnt_q != 32'hFFFF_FFFF) begin
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                        end
                    end else if (hit) begin
                        lru_q[req_set] <= ~hit_way;
                        if (p1_MemWrite_i) begin
                            dirty_q[hit_way][req_set] <= 1'b1;
                        end
                        // The retry right after a fill is not a first-try hit
                        if (!prev_done_q && hit_cnt_q != 32'hFFFF_FFFF) begin
                            hit_cnt_q <= hit_cnt_q + 32'd1;
                        end
                    end
                end
                S_MISS: begin
                    if (valid_q[victim_q][miss_set_q] && dirty_q[victim_q][miss_set_q]) begin
                        state_q <= S_WB;
                    end else begin
                        state_q <= S_REFILL;
                    end
                end
                S_WB: begin
                    if (mem_ack_i) begin
                        state_q <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        valid_q[victim_q][miss_set_q] <= 1'b1;
                        dirty_q[victim_q][miss_set_q] <= 1'b0;
                        lru_q[miss_set_q]             <= ~victim_q;
                        state_q                       <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line data and tags; refill_done and store_hit are both false while in
    // reset because the state register is held in IDLE with no valid lines
    always_ff @(posedge clk_i) begin
        if (store_hit) begin
            data_q[hit_way][req_set] <= store_line;
        end
        if (refill_done) begin
            data_q[victim_q][miss_set_q] <= mem_data_i;
            tag_q[victim_q][miss_set_q]  <= miss_tag_q;
        end
    end

    // Memory port decoded from the registered state; all fields come from
    // latched miss context so CPU changes mid-miss have no effect
    always_comb begin
        mem_enable_o = (state_q == S_WB) || (state_q == S_REFILL);
        mem_write_o  = (state_q == S_WB);
        mem_data_o   = data_q[victim_q][miss_set_q];
        mem_addr_o   = '0;
        if (state_q == S_WB) begin
            mem_addr_o = {tag_q[victim_q][miss_set_q], miss_set_q, {OFF_BITS{1'b0}}};
        end else if (state_q == S_REFILL) begin
            mem_addr_o = {miss_tag_q, miss_set_q, {OFF_BITS{1'b0}}};
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dcache_2way_top.sv
module tb_dcache_2way_top;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [255:0] mem_rdata;
  logic         mem_ack;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_addr;
  logic         mem_enable;
  logic         mem_write;
  logic [31:0]  p1_wdata;
  logic [31:0]  p1_addr;
  logic         p1_rd;
  logic         p1_wr;
  logic [31:0]  p1_rdata;
  logic         p1_stall;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [2:0]   dbg_state;

  dcache_2way_top dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack),
    .mem_data_o   (mem_wdata),
    .mem_addr_o   (mem_addr),
    .mem_enable_o (mem_enable),
    .mem_write_o  (mem_write),
    .p1_data_i    (p1_wdata),
    .p1_addr_i    (p1_addr),
    .p1_MemRead_i (p1_rd),
    .p1_MemWrite_i(p1_wr),
    .p1_data_o    (p1_rdata),
    .p1_stall_o   (p1_stall),
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural memory view (what loads must return) and the bench memory
  // (what the DUT has actually written back), both at line granularity.
  logic [255:0] ref_mem [int unsigned];
  logic [255:0] mem_arr [int unsigned];
  bit           dirty_m [int unsigned];
  int unsigned  rec_q [16][$];   // per set, resident lines, most recent first
  logic [31:0]  m_hit;
  logic [31:0]  m_miss;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
  } exp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mexp_t;

  exp_t  exp_q[$];
  mexp_t exp_mem_q[$];

  function automatic logic [255:0] init_line(input int unsigned ln);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) begin
      r[w*32 +: 32] = (ln * 32'h9E37_79B1) ^ (w * 32'h0101_0101 + 32'h5A5A_0000);
    end
    return r;
  endfunction

  function automatic logic [255:0] get_ref(input int unsigned ln);
    if (ref_mem.exists(ln)) return ref_mem[ln];
    return init_line(ln);
  endfunction

  function automatic logic [255:0] get_mem(input int unsigned ln);
    if (mem_arr.exists(ln)) return mem_arr[ln];
    return init_line(ln);
  endfunction

  // Lines still dirty in the cache are lost on reset.
  task automatic reset_model();
    for (int s = 0; s < 16; s++) rec_q[s].delete();
    dirty_m.delete();
    ref_mem = mem_arr;
    exp_q.delete();
    exp_mem_q.delete();
    m_hit  = 0;
    m_miss = 0;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t         e;
    mexp_t        m;
    int unsigned  ln;
    int unsigned  s;
    int unsigned  v;
    int           idx;
    int           w;
    logic [255:0] l;
    ln  = addr >> 5;
    s   = ln % 16;
    w   = int'((addr >> 2) & 32'd7);
    idx = -1;
    for (int i = 0; i < rec_q[s].size(); i++) begin
      if (rec_q[s][i] == ln) idx = i;
    end
    if (idx >= 0) begin
      e.hit     = 1'b1;
      e.hit_cnt = m_hit;
      m_hit     = m_hit + 1;
      rec_q[s].delete(idx);
    end else begin
      e.hit = 1'b0;
      if (rec_q[s].size() == 2) begin
        v = rec_q[s].pop_back();
        if (dirty_m.exists(v)) begin
          m.wr   = 1'b1;
          m.addr = v << 5;
          m.data = get_ref(v);
          exp_mem_q.push_back(m);
          dirty_m.delete(v);
        end
      end
      m.wr   = 1'b0;
      m.addr = ln << 5;
      m.data = '0;
      exp_mem_q.push_back(m);
      m_miss    = m_miss + 1;
      e.hit_cnt = m_hit;
    end
    e.miss_cnt = m_miss;
    rec_q[s].push_front(ln);
    l = get_ref(ln);
    if (wr) begin
      l[w*32 +: 32] = data;
      ref_mem[ln]   = l;
      dirty_m[ln]   = 1'b1;
    end
    e.wr   = wr;
    e.addr = addr;
    e.data = wr ? 32'h0 : l[w*32 +: 32];
    exp_q.push_back(e);
    p1_addr  = addr;
    p1_wdata = data;
    p1_rd    = ~wr;
    p1_wr    = wr;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (p1_stall === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL access_timeout: addr %0h still stalled after 400 cycles", p1_addr);
    end
    @(posedge clk);
    #1;
    p1_rd = 1'b0;
    p1_wr = 1'b0;
  endtask

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    issue(wr, addr, data);
    wait_done();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    reset_model();
    #1;
    check("reset_hit_cnt", hit_cnt, 0);
    check("reset_miss_cnt", miss_cnt, 0);
    check("reset_enable", mem_enable, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- memory responder ----------------
  bit ack_hold = 1'b0;
  bit spurious = 1'b0;
  int wait_cnt = 1;

  initial begin
    mexp_t m;
    int unsigned ln;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst_n) begin
        wait_cnt = 1;
      end else if (mem_enable && !ack_hold) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          ln = mem_addr >> 5;
          if (exp_mem_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mem_unexpected: wr=%0d addr %0h", mem_write, mem_addr);
          end else begin
            m = exp_mem_q.pop_front();
            check("mem_write_flag", mem_write, m.wr);
            check("mem_addr", mem_addr, m.addr);
            if (m.wr) check("wb_data", mem_wdata, m.data);
          end
          if (mem_write) mem_arr[ln] = mem_wdata;
          else mem_rdata = get_mem(ln);
          mem_ack  = 1'b1;
          wait_cnt = $urandom_range(1, 4);
        end
      end else if (!mem_enable && spurious) begin
        mem_ack  = 1'b1;
        spurious = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit stall_seen = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_seen = 1'b0;
      end else if (p1_rd || p1_wr) begin
        if (p1_stall) begin
          stall_seen = 1'b1;
          check("nonhit_data_zero", p1_rdata, 0);
        end else if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL exp_q_underflow: completion at addr %0h", p1_addr);
        end else begin
          e = exp_q.pop_front();
          check("first_try_hit", !stall_seen, e.hit);
          if (!e.wr) check("load_data", p1_rdata, e.data);
          check("hit_cnt", hit_cnt, e.hit_cnt);
          check("miss_cnt", miss_cnt, e.miss_cnt);
          stall_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0]  cap_addr;
  logic [255:0] cap_data;
  bit           seen;

  initial begin
    rst_n    = 1'b0;
    p1_rd    = 1'b0;
    p1_wr    = 1'b0;
    p1_addr  = '0;
    p1_wdata = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", mem_enable, 0);
    check("rst_write", mem_write, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    p1_rd   = 1'b1;
    p1_addr = 32'h0000_0400;
    #1;
    check("rst_stall_eq_req", p1_stall, 1);
    check("rst_data_zero", p1_rdata, 0);
    p1_rd = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: cold load miss then hit
    access(0, 32'h0000_0400, 0);
    access(0, 32'h0000_0400, 0);
    // 2: store hit and readback
    access(1, 32'h0000_0404, 32'hDEAD_BEEF);
    access(0, 32'h0000_0404, 0);

    // 3: clean victim chosen by LRU
    pulse_reset();
    access(0, 32'h0000_0000, 0);
    access(0, 32'h0000_0400, 0);
    access(0, 32'h0000_0000, 0);
    access(0, 32'h0000_0800, 0);
    access(0, 32'h0000_0004, 0);

    // 4: dirty victim written back before refill
    access(1, 32'h0000_0408, 32'h1234_5678);
    access(0, 32'h0000_0000, 0);
    access(0, 32'h0000_0800, 0);
    access(0, 32'h0000_0408, 0);

    // 6: write-back held without ack; outputs must stay stable
    access(1, 32'h0000_0800, 32'hCAFE_F00D);
    access(0, 32'h0000_0000, 0);
    ack_hold = 1'b1;
    issue(0, 32'h0000_0410, 0);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_enable && mem_write) begin
        seen = 1'b1;
        break;
      end
    end
    check("wb_reached", seen, 1);
    cap_addr = mem_addr;
    cap_data = mem_wdata;
    check("wb_hold_addr_value", cap_addr, 32'h0000_0800);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("wb_hold_addr", mem_addr, cap_addr);
      check("wb_hold_data", mem_wdata, cap_data);
      check("wb_hold_stall", p1_stall, 1);
    end
    ack_hold = 1'b0;
    wait_done();

    // spurious ack while idle
    spurious = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("spur_enable", mem_enable, 0);
    check("spur_state_idle", dbg_state, 0);
    check("spur_hit_cnt", hit_cnt, m_hit);
    check("spur_miss_cnt", miss_cnt, m_miss);
    access(0, 32'h0000_0800, 0);

    // 5: reset during refill abandons the transaction
    ack_hold = 1'b1;
    issue(0, 32'h0000_0020, 0);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_enable && !mem_write) begin
        seen = 1'b1;
        break;
      end
    end
    check("refill_reached", seen, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_enable", mem_enable, 0);
    check("midrst_hit_cnt", hit_cnt, 0);
    check("midrst_miss_cnt", miss_cnt, 0);
    check("midrst_stall", p1_stall, 1);
    p1_rd = 1'b0;
    reset_model();
    ack_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    access(0, 32'h0000_0000, 0);
    access(0, 32'h0000_0404, 0);

    // random traffic across a few conflicting sets
    for (int k = 0; k < 250; k++) begin
      logic [31:0] a;
      a = $urandom_range(0, 5) * 512 + $urandom_range(0, 3) * 32
        + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
      issue($urandom_range(0, 1), a, $urandom);
      wait_done();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_mem_q_drained", exp_mem_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
